// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED fader.
// No ports. It provides the default channel count and brightness width,
// and level_max(w), the full-scale brightness for a w-bit level register.
package led_pkg;

   localparam int unsigned LED_NLEDS   = 8;
   localparam int unsigned LED_LEVEL_W = 4;

   // Full-scale brightness for a w-bit level register: 2^w - 1
   function automatic int unsigned level_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: a brightness register plus a PWM comparator.
// Ports:
//   clock        : system clock (posedge)
//   reset        : synchronous active-high reset
//   load_i       : jump to full brightness this cycle
//   decay_tick_i : step brightness down by one (ignored if load_i)
//   pwm_cnt_i    : shared free-running PWM frame counter
//   led_o        : registered PWM drive, high while level > pwm_cnt
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int unsigned LEVEL_W = LED_LEVEL_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_i,
   input  logic               decay_tick_i,
   input  logic [LEVEL_W-1:0] pwm_cnt_i,
   output logic               led_o
);

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(level_max(LEVEL_W));

   logic [LEVEL_W-1:0] level_q, level_d;
   logic               led_q;

   // Load has priority over decay; decay saturates at zero
   always_comb begin
      level_d = level_q;
      if (load_i) begin
         level_d = LEVEL_MAX;
      end else if (decay_tick_i && (level_q != '0)) begin
         level_d = level_q - LEVEL_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         level_q <= '0;
         led_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         led_q   <= (level_q > pwm_cnt_i);
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/led_fader.sv
// LED fader: lit pattern bits jump to full brightness, then fade stepwise.
// Ports:
//   clock   : system clock (posedge)
//   reset   : synchronous active-high reset
//   i_stb   : pattern-valid strobe; i_led is sampled only while high
//   i_led   : LED pattern from the walker
//   o_led   : registered PWM drive to the LED pins
//   o_frame : registered pulse, high during the cycle pwm_cnt == 0
module led_fader
   import led_pkg::*;
#(
   parameter int unsigned NLEDS        = LED_NLEDS,
   parameter int unsigned LEVEL_W      = LED_LEVEL_W,
   parameter int unsigned DECAY_PERIOD = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_stb,
   input  logic [NLEDS-1:0] i_led,
   output logic [NLEDS-1:0] o_led,
   output logic             o_frame
);

   localparam int unsigned        DECAY_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [LEVEL_W-1:0] PWM_LAST   = LEVEL_W'(level_max(LEVEL_W) - 32'd1);
   localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_PERIOD - 32'd1);

   logic [LEVEL_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [DECAY_W-1:0] decay_cnt_q, decay_cnt_d;
   logic               frame_q;
   logic               frame_end_c;
   logic               decay_tick_c;

   assign frame_end_c  = (pwm_cnt_q == PWM_LAST);
   assign decay_tick_c = frame_end_c && (decay_cnt_q == DECAY_LAST);

   // PWM counter spans 0..MAX-1; decay counter advances once per frame
   always_comb begin
      pwm_cnt_d   = pwm_cnt_q + LEVEL_W'(1);
      decay_cnt_d = decay_cnt_q;
      if (frame_end_c) begin
         pwm_cnt_d   = '0;
         decay_cnt_d = (decay_cnt_q == DECAY_LAST) ? '0 : decay_cnt_q + DECAY_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_cnt_q   <= '0;
         decay_cnt_q <= '0;
         frame_q     <= 1'b0;
      end else begin
         pwm_cnt_q   <= pwm_cnt_d;
         decay_cnt_q <= decay_cnt_d;
         frame_q     <= frame_end_c;
      end
   end

   assign o_frame = frame_q;

   // One brightness channel per LED, all sharing the frame and decay timing
   for (genvar g = 0; g < int'(NLEDS); g++) begin : g_ch
      led_pwm_channel #(
         .LEVEL_W (LEVEL_W)
      ) u_ch (
         .clock        (clock),
         .reset        (reset),
         .load_i       (i_stb && i_led[g]),
         .decay_tick_i (decay_tick_c),
         .pwm_cnt_i    (pwm_cnt_q),
         .led_o        (o_led[g])
      );
   end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream of the LED walker: consumes the walker's 8-bit LED pattern and drives the physical LED pins.
- Each LED lit by an accepted pattern jumps to full brightness, then decays stepwise through PWM levels. The result is a fading "comet tail" behind the walking LED instead of hard on/off steps.
- Contains a free-running PWM frame counter, a decay-rate counter, and per-LED brightness registers.

Parameters:
- NLEDS, 8: number of LED channels; width of the pattern in and out.
- LEVEL_W, 4: brightness register width. MAX = 2^LEVEL_W-1 (15).
- DECAY_PERIOD, 16: PWM frames between decay steps. Legal range ≥1.

Ports:
- clock, input, 1: single system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- i_stb, input, 1: pattern-valid strobe; i_led is sampled only when i_stb=1.
- i_led, input, NLEDS: LED pattern from the walker.
- o_led, output, NLEDS: registered PWM drive to the pins.
- o_frame, output, 1: registered one-cycle pulse, high while pwm_cnt==0 (PWM frame start).

Behaviour:
- Reset (synchronous, active-high): sampled at posedge. The next cycle has:
  - level[*]=0, pwm_cnt=0, decay_cnt=0
  - o_led=0, o_frame=0
  - Reset mid-fade discards all brightness immediately; there is no residual tail.
- pwm_cnt:
  - LEVEL_W bits; counts 0..MAX-1, then wraps to 0.
  - Frame length = MAX cycles (15).
- o_frame: registered as (pwm_cnt==MAX-1), so it is high exactly the cycle pwm_cnt==0. The first pulse after reset comes MAX cycles after reset deasserts.
- decay_cnt:
  - Counts frames 0..DECAY_PERIOD-1; increments when pwm_cnt==MAX-1 and wraps to 0.
  - decay_tick = (pwm_cnt==MAX-1) && (decay_cnt==DECAY_PERIOD-1).
  - decay_tick is combinational and internal; it is high one cycle every MAX*DECAY_PERIOD cycles.
- level[i] update, evaluated each cycle in this priority:
  1. i_stb && i_led[i] → MAX. Load beats a coincident decay_tick.
  2. else decay_tick && level[i]!=0 → level[i]-1.
  3. else hold. Saturates at 0, never wraps.
  - i_stb=1 with i_led[i]=0 does not clear level[i]; this preserves the trail.
  - i_stb=0 ignores i_led entirely.
- o_led[i] <= (level[i] > pwm_cnt), registered.
  - level MAX → always on; level 0 → always off.
  - level L → on for L of MAX cycles per frame, on pwm_cnt values 0..L-1.
- Latency: i_stb sampled at edge N → level=MAX after edge N → o_led high after edge N+1.
- Tail duration: from MAX, an LED reaches 0 after MAX decay ticks, about MAX*DECAY_PERIOD frames. The first decrement is at the next decay_tick, not a full period after load.
- i_stb held high continuously is legal; lit bits are then refreshed every cycle.
- All outputs are fully registered; there are no combinational input→output paths.

Decomposition:
- Shared package led_pkg holds:
  - default constants LED_NLEDS=8, LED_LEVEL_W=4
  - function level_max(w) = 2^w-1
- Sub-module led_pwm_channel, instantiated NLEDS times via generate:
  - Inputs: clock, reset, load, decay_tick, pwm_cnt.
  - Contains the level register and the compare; output is o_led bit.
- The top level owns pwm_cnt, decay_cnt, decay_tick, and o_frame.

Test Plan:
- Reset mid-operation:
  - Stimulus: load 0xFF, run 40 cycles, assert reset 3 cycles.
  - Required: o_led=0x00 and o_frame=0 from the cycle after the first reset edge; first o_frame 15 cycles after reset release.
- Single fade (DECAY_PERIOD=2):
  - Stimulus: one-cycle i_stb with i_led=0x01.
  - Required: o_led[0] on 15/15 cycles in the frames before the first decay_tick, then 14/15, 13/15 … per 2 frames, reaching 0/15 after 15 ticks. Bits 7:1 stay 0 throughout.
- Load/decay collision:
  - Stimulus: assert i_stb, i_led=0x80 on exactly the decay_tick cycle while level[7]=9.
  - Required: level[7]=15 (not 8 or 14).
- Gating:
  - Stimulus: i_stb=0, i_led=0xFF for 100 cycles after reset.
  - Required: o_led stays 0x00.
  - Stimulus: i_stb=1, i_led=0x00 while level[3]=6.
  - Required: level[3] unchanged until the next decay_tick.
- Saturation:
  - Stimulus: level 0, run 5 decay ticks.
  - Required: level stays 0; o_led bit never pulses.
- Walker trail (DECAY_PERIOD=1):
  - Stimulus: strobe 0x01, 0x02, 0x04 once per frame.
  - Required: in the frame after the 0x04 load, duties are bit2=15, bit1=14, bit0=13.
